// File: rtl/sr_cmd_gen.sv
// Command stage for the SR flip-flop: synchronises, debounces and edge-detects
// the set/clear buttons and issues mutually exclusive single-cycle s/r pulses.
module sr_cmd_gen #(
    parameter int DB_CYCLES = 4,
    parameter int CW        = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set_in,
    input  logic          clr_in,
    input  logic          en,
    output logic          s,
    output logic          r,
    output logic          conflict,
    output logic [CW-1:0] cmd_cnt
);

    localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    // Channel index 0 is the set request, 1 is the clear request.
    logic [1:0]    sync1_q;
    logic [1:0]    sync2_q;
    logic [1:0]    db_q;
    logic [7:0]    dcnt_q [2];
    logic [1:0]    qual;

    logic          s_q, s_d;
    logic          r_q, r_d;
    logic          conflict_q, conflict_d;
    logic [CW-1:0] cmd_cnt_q, cmd_cnt_d;

    // A channel qualifies on the edge where its debounced level rises.
    always_comb begin
        qual = '0;
        for (int i = 0; i < 2; i++) begin
            qual[i] = sync2_q[i] && !db_q[i] && (dcnt_q[i] == DB_LAST);
        end
    end

    always_comb begin
        s_d        = qual[0] && !qual[1] && en;
        r_d        = qual[1] && !qual[0] && en;
        conflict_d = qual[0] && qual[1];
        cmd_cnt_d  = cmd_cnt_q;
        if ((s_d || r_d) && (cmd_cnt_q != CNT_MAX)) begin
            cmd_cnt_d = cmd_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            for (int i = 0; i < 2; i++) begin
                dcnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= {clr_in, set_in};
            sync2_q <= sync1_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == db_q[i]) begin
                    dcnt_q[i] <= '0;
                end else if (dcnt_q[i] == DB_LAST) begin
                    db_q[i]   <= sync2_q[i];
                    dcnt_q[i] <= '0;
                end else begin
                    dcnt_q[i] <= dcnt_q[i] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            conflict_q <= 1'b0;
            cmd_cnt_q  <= '0;
        end else begin
            s_q        <= s_d;
            r_q        <= r_d;
            conflict_q <= conflict_d;
            cmd_cnt_q  <= cmd_cnt_d;
        end
    end

    assign s        = s_q;
    assign r        = r_q;
    assign conflict = conflict_q;
    assign cmd_cnt  = cmd_cnt_q;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Bench for sr_cmd_gen: window-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized bouncy inputs.
module tb_sr_cmd_gen;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       set_in = 1'b0;
    logic       clr_in = 1'b0;
    logic       en = 1'b1;
    logic       s, r, conflict;
    logic [7:0] cmd_cnt;
    logic       s2, r2, conflict2;
    logic [1:0] cmd_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sr_cmd_gen #(.DB_CYCLES(DB), .CW(8)) dut (
        .clk(clk), .rst(rst), .set_in(set_in), .clr_in(clr_in), .en(en),
        .s(s), .r(r), .conflict(conflict), .cmd_cnt(cmd_cnt)
    );

    sr_cmd_gen #(.DB_CYCLES(DB), .CW(2)) dut_sat (
        .clk(clk), .rst(rst), .set_in(set_in), .clr_in(clr_in), .en(en),
        .s(s2), .r(r2), .conflict(conflict2), .cmd_cnt(cmd_cnt2)
    );

    // Reference model: raw input reaches the debouncer two edges late; the
    // debounced level flips once the last DB observed values all differ from it.
    bit          m_p1 [2];
    bit          m_p2 [2];
    bit          m_db [2];
    bit          m_hist [2][DB];
    bit          m_q [2];
    bit          m_in [2];
    bit          m_seen;
    bit          m_all;
    bit          e_s, e_r, e_c;
    int unsigned m_cnt;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < 2; c++) begin
                m_p1[c] = 0; m_p2[c] = 0; m_db[c] = 0; m_q[c] = 0;
                for (int k = 0; k < DB; k++) m_hist[c][k] = 0;
            end
            e_s = 0; e_r = 0; e_c = 0; m_cnt = 0;
        end else begin
            m_in[0] = set_in;
            m_in[1] = clr_in;
            for (int c = 0; c < 2; c++) begin
                m_seen  = m_p2[c];
                m_p2[c] = m_p1[c];
                m_p1[c] = m_in[c];
                for (int k = DB - 1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
                m_hist[c][0] = m_seen;
                m_all = 1;
                for (int k = 0; k < DB; k++) if (m_hist[c][k] == m_db[c]) m_all = 0;
                m_q[c] = 0;
                if (m_all) begin
                    m_db[c] = m_seen;
                    m_q[c]  = m_seen;
                end
            end
            e_s = m_q[0] && !m_q[1] && en;
            e_r = m_q[1] && !m_q[0] && en;
            e_c = m_q[0] && m_q[1];
            if (e_s || e_r) m_cnt++;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #4;
        chk("model_s", int'(s), int'(e_s));
        chk("model_r", int'(r), int'(e_r));
        chk("model_conflict", int'(conflict), int'(e_c));
        chk("model_cnt", int'(cmd_cnt), (m_cnt > 255) ? 255 : int'(m_cnt));
        chk("model_s_sat", int'(s2), int'(e_s));
        chk("model_r_sat", int'(r2), int'(e_r));
        chk("model_conflict_sat", int'(conflict2), int'(e_c));
        chk("model_cnt_sat", int'(cmd_cnt2), (m_cnt > 3) ? 3 : int'(m_cnt));
        chk("s_and_r", int'(s & r), 0);
    end

    task automatic wait_edge();
        @(posedge clk);
        #4;
    endtask

    // Watch n edges; the pulse columns give the edge index where each output
    // must be high (-1 = never).
    task automatic watch(input int n, input int s_at, input int r_at, input int c_at);
        for (int k = 0; k < n; k++) begin
            wait_edge();
            chk("lit_s", int'(s), int'(k == s_at));
            chk("lit_r", int'(r), int'(k == r_at));
            chk("lit_conflict", int'(conflict), int'(k == c_at));
        end
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b0;
        #1;
        chk("rst_s", int'(s), 0);
        chk("rst_r", int'(r), 0);
        chk("rst_conflict", int'(conflict), 0);
        chk("rst_cnt", int'(cmd_cnt), 0);
        chk("rst_cnt_sat", int'(cmd_cnt2), 0);
        set_in = 1'b1;
        clr_in = 1'b1;
        wait_edge();
        set_in = 1'b0;
        wait_edge();
        chk("rst_hold_s", int'(s), 0);
        chk("rst_hold_r", int'(r), 0);
        chk("rst_hold_conflict", int'(conflict), 0);
        clr_in = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    initial begin
        #1;
        rst = 1'b0;
        #1;
        chk("init_s", int'(s), 0);
        chk("init_cnt", int'(cmd_cnt), 0);
        rst = 1'b1;
        en = 1'b1;

        // Clean press then release
        do_reset();
        set_in = 1'b1;
        watch(8, 5, -1, -1);
        chk("press_cnt", int'(cmd_cnt), 1);
        set_in = 1'b0;
        watch(10, -1, -1, -1);
        chk("release_cnt", int'(cmd_cnt), 1);

        // Bounce: 3 high, 1 low, then stable high
        do_reset();
        set_in = 1'b1;
        watch(3, -1, -1, -1);
        set_in = 1'b0;
        watch(1, -1, -1, -1);
        set_in = 1'b1;
        watch(8, 5, -1, -1);
        chk("bounce_cnt", int'(cmd_cnt), 1);
        set_in = 1'b0;
        watch(8, -1, -1, -1);

        // Simultaneous press, then a sole clear
        do_reset();
        set_in = 1'b1;
        clr_in = 1'b1;
        watch(8, -1, -1, 5);
        chk("conflict_cnt", int'(cmd_cnt), 0);
        set_in = 1'b0;
        clr_in = 1'b0;
        watch(10, -1, -1, -1);
        clr_in = 1'b1;
        watch(8, -1, 5, -1);
        chk("clr_cnt", int'(cmd_cnt), 1);
        clr_in = 1'b0;
        watch(8, -1, -1, -1);

        // Enable gating: the event is dropped, not queued
        do_reset();
        en = 1'b0;
        set_in = 1'b1;
        watch(8, -1, -1, -1);
        en = 1'b1;
        watch(6, -1, -1, -1);
        chk("gated_cnt", int'(cmd_cnt), 0);
        set_in = 1'b0;
        watch(8, -1, -1, -1);

        // Saturation of the 2-bit counter
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) begin
                set_in = 1'b1;
                watch(8, 5, -1, -1);
            end else begin
                clr_in = 1'b1;
                watch(8, -1, 5, -1);
            end
            set_in = 1'b0;
            clr_in = 1'b0;
            watch(8, -1, -1, -1);
        end
        chk("sat_cnt2", int'(cmd_cnt2), 3);
        chk("sat_cnt8", int'(cmd_cnt), 5);

        // Mid-qualification reset
        do_reset();
        set_in = 1'b1;
        watch(4, -1, -1, -1);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_s", int'(s), 0);
        #2;
        rst = 1'b1;
        watch(8, 5, -1, -1);
        chk("midrst_cnt", int'(cmd_cnt), 1);
        set_in = 1'b0;
        watch(8, -1, -1, -1);

        // Randomized bouncy buttons, enable changes and occasional resets
        for (int n = 0; n < 4000; n++) begin
            wait_edge();
            if ($urandom_range(0, 5) == 0) set_in = ~set_in;
            if ($urandom_range(0, 5) == 0) clr_in = ~clr_in;
            if ($urandom_range(0, 40) == 0) en = ~en;
            if ($urandom_range(0, 700) == 0) begin
                #2;
                rst = 1'b0;
                #2;
                rst = 1'b1;
            end
        end
        wait_edge();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sr_cmd_gen.md
# sr_cmd_gen

- Upstream command stage for the team's SR flip-flop (ports `s`, `r`).
- Takes two asynchronous, bouncy button lines (set request, clear request) and synchronises each. It debounces each and edge-detects it, then issues clean single-cycle `s` / `r` pulses.
- It guarantees that `s` and `r` are never high together, so the downstream flip-flop never enters its invalid `{s,r}=2'b11` state.
- Simultaneous requests are flagged and dropped. Issued commands are counted.

## Interface
Parameters:
- `DB_CYCLES`, 4 — consecutive stable synchronised cycles required to accept a level change; legal range 2..255.
- `CW`, 8 — width of the issued-command counter.

Ports:
- `clk` input 1 — single clock; all state updates on its rising edge.
- `rst` input 1 — asynchronous, active-low reset.
- `set_in` input 1 — raw set-button level; asynchronous, may bounce.
- `clr_in` input 1 — raw clear-button level; asynchronous, may bounce.
- `en` input 1 — command enable (synchronous). When 0, pulses are suppressed but debouncing continues.
- `s` output 1 — one-cycle set pulse to the SR flip-flop.
- `r` output 1 — one-cycle reset pulse to the SR flip-flop.
- `conflict` output 1 — one-cycle flag: both channels qualified in the same cycle.
- `cmd_cnt` output CW — number of issued `s`/`r` pulses; saturating.

## Operation
Per channel (set and clear are identical and independent):
- Synchroniser: two flops, `sync1 <= x_in`, `sync2 <= sync1`.
- Debouncer state: `db` level, initially 0, plus counter `dcnt` of 8 bits.
  - If `sync2 == db`: `dcnt <= 0`.
  - Else if `dcnt == DB_CYCLES-1`: `db <= sync2`, `dcnt <= 0`.
  - Else: `dcnt <= dcnt+1`.
  - Any bounce back to `db` restarts qualification from 0.
- Qualification event `q_x` occurs on the edge where `db` updates 0->1.
- A 1->0 update of `db` produces no command.

Output logic, registered and evaluated on the same edge as the `db` update:
- `q_set & ~q_clr & en` → `s <= 1`.
- `q_clr & ~q_set & en` → `r <= 1`.
- `q_set & q_clr` → `s <= 0`, `r <= 0`, `conflict <= 1`. This applies regardless of `en`.
- Otherwise `s`, `r` and `conflict` are all 0 next cycle. All pulses are exactly one cycle wide.
- `en == 0` with a single qualification: the event is discarded, not queued.
- `cmd_cnt` increments by 1 on each edge that sets `s` or `r`. It holds at `2^CW-1` and never wraps. It does not count conflicts.
- Invariant: `s & r` is never 1.

Reset (`rst == 0`, asynchronous):
- `s`, `r` and `conflict` are 0.
- `cmd_cnt`, all sync flops, `db` and `dcnt` are 0.
- Mid-operation reset aborts any qualification in progress.
- After release, a button still held high re-qualifies from scratch and issues a fresh pulse after full latency.

## Timing
Edge numbering: input stable high before edge E0; edges counted from E0.
- `sync1` is high after E0; `sync2` is high after E1.
- `dcnt` counts on E2..E(DB_CYCLES).
- `db` and `s`/`r` go high after E(DB_CYCLES+1).
- The pulse drops after E(DB_CYCLES+2).
- With `DB_CYCLES=4`: pulse high between E5 and E6.
- Release: `db` returns to 0 with the same latency; no output pulse.
- A new pulse requires release to qualify first, then press to qualify again.
- Reset deassertion: the first functional edge is the first rising `clk` after `rst` goes high.
- No throughput limit other than the debounce latency.

## Test plan
- Reset: hold `rst=0` and toggle inputs. Required: `s=r=conflict=0`, `cmd_cnt=0`, asynchronously and before any edge.
- Clean press, `DB_CYCLES=4`, `en=1`: `set_in` 0->1 stable before E0. Required: `s=1` only in the cycle after E5, `r=0` throughout, `cmd_cnt=1`. Releasing `set_in` gives no pulse.
- Bounce: `set_in` high for 3 cycles, low for 1, then high stable. Required: no `s` during the bounce; exactly one `s` pulse, 6 edges after the final rising input; `cmd_cnt=1`.
- Simultaneous: `set_in` and `clr_in` rise in the same cycle. Required: `conflict=1` for one cycle after E5, `s=r=0`, `cmd_cnt` unchanged. A following sole `clr_in` press gives `r=1` and `cmd_cnt=1`.
- Enable gating and saturation: with `en=0`, a press produces no `s` and `cmd_cnt` holds. With `CW=2`, five alternating set/clear presses leave `cmd_cnt=3`.
- Mid-qualification reset: `rst` pulsed low at E3 while `set_in` is held high. Required: no pulse before reset; after release, `s` pulses `DB_CYCLES+2` edges later.
